ps2_key_encoder: RTL and testbench
==================================

PS2_KEY_ENCODER -- requirements
Module: ps2_key_encoder

Interface
REQ-001 Parameter FILT, default 8: consecutive equal samples required before the filtered ps2_clk changes level.
REQ-002 Parameter TIMEOUT, default 48000: clk_sys cycles without a filtered falling edge before a partial frame is aborted (1 ms at 48 MHz).
REQ-003 clk_sys  input  1  single clock; all state is updated on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk_sys.
REQ-006 ps2_data  input  1  raw PS/2 data, asynchronous to clk_sys.
REQ-007 ps2_key  output  11  key event word: [10] toggles once per event, [9] pressed, [8] extended (E0), [7:0] scancode.
REQ-008 frame_err  output  1  one-cycle pulse for each dropped or aborted frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer before any other use.
REQ-010 The filtered clock SHALL change only after FILT consecutive identical synchronized samples; shorter pulses SHALL have no effect.
REQ-011 ps2_data SHALL be sampled in the cycle a filtered 1->0 transition of ps2_clk is detected.
REQ-012 Frame format SHALL be 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1. A 4-bit counter SHALL track bits 0..10.
REQ-013 A start bit sampled as 1 SHALL be discarded silently: counter stays at 0, no frame_err.
REQ-014 Bad parity or a stop bit of 0 SHALL drop the byte, pulse frame_err for 1 cycle, return the counter to 0 and return the prefix FSM to IDLE.
REQ-015 While the counter is nonzero, a saturating idle counter SHALL count cycles without a falling edge.
REQ-016 When the idle counter reaches TIMEOUT, the partial frame SHALL be aborted: counter to 0, frame_err pulsed, prefix FSM to IDLE.
REQ-017 The idle counter SHALL clear on every sampled edge.
REQ-018 Valid bytes SHALL drive the prefix FSM, with states IDLE, EXT, REL and EXT_REL.
REQ-019 Byte E0 SHALL set the ext flag in any state: IDLE->EXT, REL->EXT_REL.
REQ-020 Byte F0 SHALL set the rel flag in any state: IDLE->REL, EXT->EXT_REL.
REQ-021 Bytes 00, AA, E1, EE, FA, FE and FF SHALL be ignored in every state, and the FSM state SHALL be kept.
REQ-022 Any other byte SHALL emit one event and return the FSM to IDLE.
REQ-023 An event SHALL set ps2_key[9] = ~rel, [8] = ext, [7:0] = byte, and invert [10].
REQ-024 All 11 bits of ps2_key SHALL update in the same cycle, exactly 1 clk_sys after the stop-bit sample.
REQ-025 ps2_key SHALL hold its value between events.
REQ-026 If a frame error and a timeout coincide, only one frame_err pulse SHALL be generated.
REQ-027 frame_err SHALL never be high for 2 consecutive cycles.

Reset
REQ-028 While reset_n=0 at a clk_sys edge, the following SHALL be cleared: ps2_key to 11'h000, frame_err to 0, bit counter to 0, idle counter to 0, FSM to IDLE.
REQ-029 During reset, the synchronizers and filter SHALL be preset to 1 (bus idle), so that no edge is detected on release.
REQ-030 A reset asserted mid-frame SHALL discard the partial byte and any pending prefix, and SHALL produce no event and no frame_err.

Verification
REQ-031 From reset, send 29 (make) -> ps2_key = 11'h629, 1 cycle after stop-bit sample; frame_err stays 0.
REQ-032 Then send F0, 29 -> exactly one event, ps2_key = 11'h029; no event after F0 alone.
REQ-033 Then send E0, 75 -> ps2_key = 11'h775; then send E0, F0, 75 -> ps2_key = 11'h175.
REQ-034 Send byte 16 with parity flipped -> single 1-cycle frame_err pulse, ps2_key unchanged.
- Then send a clean 16 -> bits [9:0] = 10'h216, bit [10] inverted.
REQ-035 Send 5 bits of a frame, then hold ps2_clk high for TIMEOUT+10 cycles -> one frame_err pulse.
- A following clean FA produces no event.
- A following clean 1C produces an event with [9:0] = 10'h21C.
REQ-036 Inject 3-cycle low glitches on ps2_clk (FILT=8) between valid bits of byte 29 -> decoded event unchanged ([7:0] = 29), frame_err stays 0.
REQ-037 Assert reset_n=0 after bit 4 of a frame, then release -> ps2_key = 000 and no frame_err.
- The next full frame 29 SHALL yield 11'h629.

Source files
------------

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches the bus, deframes 11-bit
// frames and folds E0/F0 prefixes into a toggling 11-bit key event word.
module ps2_key_encoder #(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 48000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_REL     = 2'd2;
  localparam logic [1:0] S_EXT_REL = 2'd3;

  logic [1:0]    clk_sync, dat_sync;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt, clk_filt_d;
  logic          fall, dat;

  logic [3:0]    bit_cnt;
  logic [7:0]    data_sr;
  logic          par;
  logic [TW-1:0] idle_cnt;
  logic [1:0]    state;
  logic          byte_ok, byte_ignored;

  // Synchronizers and filter preset to the idle-high bus level so reset release
  // never looks like a falling edge.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt)
        filt_cnt <= '0;
      else if (filt_cnt == FW'(FILT - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else
        filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign fall = clk_filt_d & ~clk_filt;
  assign dat  = dat_sync[1];

  // Odd parity over data+parity, plus a high stop bit.
  assign byte_ok = (^{data_sr, par}) & dat;

  always_comb begin
    byte_ignored = 1'b0;
    case (data_sr)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: byte_ignored = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      data_sr   <= '0;
      par       <= 1'b0;
      idle_cnt  <= '0;
      state     <= S_IDLE;
      ps2_key   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        case (bit_cnt)
          4'd0: if (!dat) bit_cnt <= 4'd1;
          4'd9: begin
            par     <= dat;
            bit_cnt <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= '0;
            if (!byte_ok) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end else if (data_sr == 8'hE0)
              state <= state | S_EXT;
            else if (data_sr == 8'hF0)
              state <= state | S_REL;
            else if (!byte_ignored) begin
              ps2_key <= {~ps2_key[10], ~state[1], state[0], data_sr};
              state   <= S_IDLE;
            end
          end
          default: begin
            data_sr <= {dat, data_sr[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        endcase
      end else if (bit_cnt != 4'd0) begin
        // Stalled mid-frame: abort once the bus has been quiet too long.
        if (idle_cnt >= TW'(TIMEOUT)) begin
          idle_cnt  <= '0;
          bit_cnt   <= '0;
          frame_err <= 1'b1;
          state     <= S_IDLE;
        end else
          idle_cnt <= idle_cnt + 1'b1;
      end else
        idle_cnt <= '0;
    end
  end

  // S_EXT_REL is reached only through the OR-in of the two prefix flags.
  logic unused_ok;
  assign unused_ok = &{1'b0, S_EXT_REL};

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: directed frames, then random byte streams checked
// against an event-level model of the prefix/toggle rules.
module tb_ps2_key_encoder;
  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 30;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_encoder #(.FILT(FILT), .TIMEOUT(TMO)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0, n_err = 0;
  int err_pulses = 0, evt_cnt = 0;
  bit err_dbl = 0, prev_err = 0, prev_tog = 0;

  // Observe pulses and events away from the active edge.
  always @(negedge clk_sys) begin
    if (frame_err === 1'b1) err_pulses++;
    if (frame_err === 1'b1 && prev_err) err_dbl = 1;
    prev_err = (frame_err === 1'b1);
    if (reset_n && ps2_key[10] !== prev_tog) evt_cnt++;
    prev_tog = (ps2_key[10] === 1'b1);
  end

  // Reference model at key-event level.
  bit          m_ext = 0, m_rel = 0, m_tog = 0;
  logic [10:0] m_key = '0;
  int          m_err = 0, m_evt = 0;

  task automatic model(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_err++; m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else if (!(b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
      m_tog = ~m_tog;
      m_evt++;
      m_key = {m_tog, ~m_rel, m_ext, b};
      m_ext = 0; m_rel = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic send_bit(input bit v, input bit glitch);
    ps2_data = v;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
    if (glitch) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
    ps2_data = 1'b1;
  endtask

  task automatic frame_chk(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit glitch);
    send_frame(b, bad_par, bad_stop, glitch, 11);
    model(b, bad_par | bad_stop);
    wait_cyc(5);
    chk("key", ps2_key, m_key);
    chk("err_cnt", err_pulses, m_err);
    chk("evt_cnt", evt_cnt, m_evt);
  endtask

  logic [7:0] pick;
  int         sel;

  initial begin
    wait_cyc(4);
    @(negedge clk_sys);
    chk("rst_key", ps2_key, 11'h000);
    chk("rst_err", frame_err, 1'b0);
    reset_n = 1'b1;
    wait_cyc(10);

    frame_chk(8'h29, 0, 0, 0);
    chk("make_29", ps2_key, 11'h629);
    frame_chk(8'hF0, 0, 0, 0);
    chk("f0_no_evt", evt_cnt, 1);
    frame_chk(8'h29, 0, 0, 0);
    chk("brk_29", ps2_key, 11'h029);
    frame_chk(8'hE0, 0, 0, 0);
    frame_chk(8'h75, 0, 0, 0);
    chk("ext_75", ps2_key, 11'h775);
    frame_chk(8'hE0, 0, 0, 0);
    frame_chk(8'hF0, 0, 0, 0);
    frame_chk(8'h75, 0, 0, 0);
    chk("extbrk_75", ps2_key, 11'h175);

    frame_chk(8'h16, 1, 0, 0);
    chk("badpar_key", ps2_key, 11'h175);
    frame_chk(8'h16, 0, 0, 0);
    chk("clean_16", ps2_key, {1'b1, 10'h216});

    // Stall a partial frame past the timeout.
    send_frame(8'h1C, 0, 0, 0, 5);
    wait_cyc(TMO + 10);
    m_err++; m_ext = 0; m_rel = 0;
    chk("tmo_err", err_pulses, m_err);
    frame_chk(8'hFA, 0, 0, 0);
    frame_chk(8'h1C, 0, 0, 0);
    chk("after_tmo", ps2_key[9:0], 10'h21C);

    frame_chk(8'h29, 0, 0, 1);
    chk("glitch_29", ps2_key[7:0], 8'h29);

    // Reset in the middle of a frame.
    send_frame(8'h29, 0, 0, 0, 5);
    reset_n = 1'b0;
    wait_cyc(3);
    @(negedge clk_sys);
    chk("midrst_key", ps2_key, 11'h000);
    reset_n = 1'b1;
    m_tog = 0; m_key = '0; m_ext = 0; m_rel = 0;
    wait_cyc(10);
    chk("midrst_err", err_pulses, m_err);
    frame_chk(8'h29, 0, 0, 0);
    chk("post_rst_29", ps2_key, 11'h629);

    for (int i = 0; i < 30; i++) begin
      sel  = $urandom_range(0, 9);
      pick = 8'($urandom);
      case (sel)
        0, 1: pick = 8'hE0;
        2:    pick = 8'hF0;
        3:    pick = 8'hAA;
        default: ;
      endcase
      frame_chk(pick, sel == 4, sel == 5, $urandom_range(0, 1) == 1);
    end

    chk("no_dbl_err", err_dbl, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
